pc_update_unit: RTL
===================

# pc_update_unit

Owns the program counter and exception program counter (EPC) of the multicycle core. Sits directly downstream of the PC-source selector: it takes the selected next-PC value and commits it under unconditional or branch-conditional write control. On an exception it runs a short sequence: it saves EPC, fetches the handler vector byte from memory, and loads PC from that byte. Its `pc` and `epc` outputs feed back into the PC-source selector and the ALU/memory address paths.

## Interface
- `WIDTH`, 32, datapath width
- `RESET_PC`, 0, PC value after reset
- `VEC_OPCODE`, 253, vector byte address for the invalid-opcode cause
- `VEC_OVERFLOW`, 254, vector byte address for the overflow cause
- `VEC_DIV0`, 255, vector byte address for the divide-by-zero cause
- `TIMEOUT_CYCLES`, 16, watchdog limit (used only with `PC_EXC_TIMEOUT_EN`)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted at 0)
- `pc_next`  in  WIDTH  selected next-PC value from the PC-source selector
- `pc_write`  in  1  unconditional PC write
- `pc_write_cond`  in  1  PC write gated by the branch condition
- `branch_op`  in  2  00 beq, 01 bne, 10 ble, 11 bgt
- `alu_zero`  in  1  ALU zero flag
- `alu_gt`  in  1  ALU greater-than flag
- `exc_req`  in  1  exception request
- `exc_cause`  in  2  00 none, 01 opcode, 10 overflow, 11 div0
- `mem_vec_req`  out  1  vector fetch request
- `mem_vec_addr`  out  WIDTH  vector byte address
- `mem_vec_ack`  in  1  vector byte valid
- `mem_vec_byte`  in  8  vector byte
- `pc`  out  WIDTH  current PC
- `epc`  out  WIDTH  saved PC
- `exc_cause_q`  out  2  latched cause
- `exc_busy`  out  1  exception sequence in progress
- `exc_timeout`  out  1  sticky watchdog flag (constant 0 without the macro)

## Operation
- Reset values:
  - `pc` = `RESET_PC`
  - `epc`, `mem_vec_addr`, `exc_cause_q` = 0
  - `mem_vec_req`, `exc_busy`, `exc_timeout` = 0
  - state IDLE
- Reset mid-sequence aborts the sequence immediately. Every output returns to its reset value.
- Branch condition:
  - beq: `alu_zero`
  - bne: `!alu_zero`
  - ble: `alu_zero | !alu_gt`
  - bgt: `alu_gt`
- In IDLE, PC loads `pc_next` when `pc_write | (pc_write_cond & cond)`.
- States:
  - IDLE
    - An exception request is taken when `exc_req=1` and `exc_cause!=00`. `exc_req` with cause 00 is ignored.
    - When taken: `epc <= pc - 4`, computed modulo 2^WIDTH (pc=0 gives 0xFFFFFFFC for WIDTH=32).
    - Also latch `exc_cause_q`, load `mem_vec_addr` with the cause's vector, and go to FETCH.
    - Any PC write in that same cycle is suppressed; the exception wins.
  - FETCH
    - `mem_vec_req=1`, `exc_busy=1`, `mem_vec_addr` held stable.
    - On an edge with `mem_vec_ack=1`: `pc <= zero-extend(mem_vec_byte)`, drop the request, return to IDLE.
    - `pc_write`, `pc_write_cond` and `exc_req` are ignored; requests arriving here are dropped, not queued.
- `mem_vec_ack` outside FETCH is ignored.

## Timing
- PC write: `pc` updates on the edge where the write condition is true. Zero added latency.
- Exception: `exc_req` is sampled at edge k. `epc` and `exc_cause_q` are valid after edge k, and `mem_vec_req` is high from edge k until the ack edge.
- Ack sampled at edge m ≥ k+1: new `pc` is visible after edge m. `exc_busy` and `mem_vec_req` fall after edge m.
- Minimum exception-to-handler latency is 2 edges.
- A new exception is accepted at edge m+1 at the earliest.

## Configuration
- `PC_EXC_TIMEOUT_EN` defined:
  - A cycle counter runs in FETCH.
  - If no ack arrives within `TIMEOUT_CYCLES` FETCH cycles, the next edge sets `pc <= RESET_PC`, sets `exc_timeout=1` (sticky until reset) and returns to IDLE.
  - A late ack after that is ignored.
- `PC_EXC_TIMEOUT_EN` undefined: FETCH waits for the ack indefinitely, no counter is built, and `exc_timeout` is tied to 0.

## Structure
- Package `pc_pkg`:
  - `branch_op` enum
  - cause enum
  - FSM state enum
  - default vector address constants
- Sub-module `pc_branch_cond`: combinational condition from `branch_op`, `alu_zero` and `alu_gt`.

## Test plan
- Reset release: `pc`=`RESET_PC`=0, `epc`=0, `exc_busy`=0 → next `pc_write` with `pc_next`=0x40 gives `pc`=0x40 after one edge.
- `pc_write_cond`=1, bne with `alu_zero`=1: no update. Then `alu_zero`=0, `pc_next`=0x80: `pc`=0x80. Check ble with `zero`=0, `gt`=0: taken.
- `pc`=0x104 when `exc_req` is raised with cause 10 and `pc_write`=1 in the same cycle:
  - After that edge: `epc`=0x100, `mem_vec_addr`=254, `pc` unchanged.
  - Ack 3 cycles later with byte 0xA0: `pc`=0x000000A0.
- Exception at `pc`=0: `epc`=0xFFFFFFFC. Byte 0xFF loads `pc`=0x000000FF (zero-extended, not sign-extended).
- Reset asserted during FETCH: `mem_vec_req` and `exc_busy` drop asynchronously, `pc`=`RESET_PC`. A second `exc_req` during FETCH is dropped.
- With `PC_EXC_TIMEOUT_EN` and no ack for 16 cycles: `pc`=`RESET_PC`, `exc_timeout`=1. A late ack does not change `pc`.

Source files
------------

// File: rtl/pc_pkg.sv
// ==== pc_pkg: shared types and default vector addresses for the PC update unit ====
// ==== Rev 1.0 ====
`default_nettype none

package pc_pkg;

  typedef enum logic [1:0] {
    BR_EQ = 2'b00,
    BR_NE = 2'b01,
    BR_LE = 2'b10,
    BR_GT = 2'b11
  } branch_op_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_OPCODE   = 2'b01,
    CAUSE_OVERFLOW = 2'b10,
    CAUSE_DIV0     = 2'b11
  } exc_cause_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } pc_state_t;

  localparam int DEF_VEC_OPCODE   = 253;
  localparam int DEF_VEC_OVERFLOW = 254;
  localparam int DEF_VEC_DIV0     = 255;

endpackage

`default_nettype wire

// File: rtl/pc_branch_cond.sv
// ==== pc_branch_cond: branch-taken condition from branch_op and ALU flags ====
// ==== Rev 1.0 ====
`default_nettype none

module pc_branch_cond
  import pc_pkg::*;
(
  input  branch_op_t branch_op,
  input  logic       alu_zero,
  input  logic       alu_gt,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    case (branch_op)
      BR_EQ:   cond = alu_zero;
      BR_NE:   cond = !alu_zero;
      BR_LE:   cond = alu_zero | !alu_gt;
      BR_GT:   cond = alu_gt;
      default: cond = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pc_update_unit.sv
// ==== pc_update_unit: PC/EPC commit and exception vector fetch; PC_EXC_TIMEOUT_EN adds a FETCH watchdog ====
// ==== Rev 1.0 ====
`default_nettype none

module pc_update_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH          = 32,
  parameter logic [WIDTH-1:0] RESET_PC       = '0,
  parameter int               VEC_OPCODE     = DEF_VEC_OPCODE,
  parameter int               VEC_OVERFLOW   = DEF_VEC_OVERFLOW,
  parameter int               VEC_DIV0       = DEF_VEC_DIV0,
  parameter int               TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_next,
  input  logic             pc_write,
  input  logic             pc_write_cond,
  input  logic [1:0]       branch_op,
  input  logic             alu_zero,
  input  logic             alu_gt,
  input  logic             exc_req,
  input  logic [1:0]       exc_cause,
  output logic             mem_vec_req,
  output logic [WIDTH-1:0] mem_vec_addr,
  input  logic             mem_vec_ack,
  input  logic [7:0]       mem_vec_byte,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] epc,
  output logic [1:0]       exc_cause_q,
  output logic             exc_busy,
  output logic             exc_timeout
);

  pc_state_t        state;
  logic             cond;
  logic             exc_take;
  logic             pc_load;
  logic [WIDTH-1:0] vec_sel;

  pc_branch_cond u_branch_cond (
    .branch_op (branch_op_t'(branch_op)),
    .alu_zero  (alu_zero),
    .alu_gt    (alu_gt),
    .cond      (cond)
  );

  assign exc_take = exc_req && (exc_cause != CAUSE_NONE);
  assign pc_load  = pc_write | (pc_write_cond & cond);

  always_comb begin
    vec_sel = '0;
    case (exc_cause_t'(exc_cause))
      CAUSE_OPCODE:   vec_sel = WIDTH'(VEC_OPCODE);
      CAUSE_OVERFLOW: vec_sel = WIDTH'(VEC_OVERFLOW);
      CAUSE_DIV0:     vec_sel = WIDTH'(VEC_DIV0);
      default:        vec_sel = '0;
    endcase
  end

`ifdef PC_EXC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] fetch_cnt;
  logic             timeout_flag;
  logic             timeout_hit;

  // Counter holds the number of ack-less FETCH edges seen so far.
  assign timeout_hit = (fetch_cnt == CNT_W'(TIMEOUT_CYCLES));
  assign exc_timeout = timeout_flag;
`else
  assign exc_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      pc           <= RESET_PC;
      epc          <= '0;
      exc_cause_q  <= '0;
      mem_vec_addr <= '0;
      mem_vec_req  <= 1'b0;
      exc_busy     <= 1'b0;
`ifdef PC_EXC_TIMEOUT_EN
      fetch_cnt    <= '0;
      timeout_flag <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          // An accepted exception takes priority over any same-cycle PC write.
          if (exc_take) begin
            epc          <= pc - WIDTH'(4);
            exc_cause_q  <= exc_cause;
            mem_vec_addr <= vec_sel;
            mem_vec_req  <= 1'b1;
            exc_busy     <= 1'b1;
            state        <= ST_FETCH;
`ifdef PC_EXC_TIMEOUT_EN
            fetch_cnt    <= '0;
`endif
          end else if (pc_load) begin
            pc <= pc_next;
          end
        end
        ST_FETCH: begin
          if (mem_vec_ack) begin
            pc          <= {{(WIDTH-8){1'b0}}, mem_vec_byte};
            mem_vec_req <= 1'b0;
            exc_busy    <= 1'b0;
            state       <= ST_IDLE;
          end
`ifdef PC_EXC_TIMEOUT_EN
          else if (timeout_hit) begin
            pc           <= RESET_PC;
            timeout_flag <= 1'b1;
            mem_vec_req  <= 1'b0;
            exc_busy     <= 1'b0;
            state        <= ST_IDLE;
          end else begin
            fetch_cnt <= fetch_cnt + 1'b1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
